half_predict_driver: RTL and testbench

- Initiator-side controller for the half-precision inference core's start/done interface.
- Per request: accepts a labelled sample request, pulses pred_start, waits for the rising edge of pred_done, snapshots the OUTPUT_NODES half-precision scores, and finds the argmax with a sequential scan.
- Reports class, max score, correctness and timeout status; keeps running total/correct counters for accuracy measurement.

---
 rtl/half_pkg.sv | 37 +++
 rtl/half_gt.sv | 17 +
 rtl/half_predict_driver.sv | 166 ++++++++++++++++
 tb/tb_half_predict_driver.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/half_pkg.sv
// Purpose: shared half-precision types, constants and ordering helpers.
// Latency: pure combinational functions, no state.
// Backpressure: n/a (no handshakes).
package half_pkg;

  typedef logic [15:0] half_t;

  localparam logic [4:0] HALF_EXP_MAX  = 5'd31;
  localparam half_t      HALF_POS_ZERO = 16'h0000;
  localparam half_t      HALF_NEG_ZERO = 16'h8000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT,
    ST_SCAN,
    ST_REPORT
  } drv_state_t;

  function automatic logic half_is_nan(input half_t h);
    return (h[14:10] == HALF_EXP_MAX) && (h[9:0] != 10'd0);
  endfunction

  // Monotonic unsigned key: negatives are bit-inverted, positives get the
  // top bit set, so a plain unsigned compare orders the values. -0 is mapped
  // onto the key of +0 so the two compare equal. NaN is handled by callers.
  function automatic half_t half_order_key(input half_t h);
    if (h == HALF_NEG_ZERO) begin
      return HALF_POS_ZERO | 16'h8000;
    end else if (h[15]) begin
      return ~h;
    end else begin
      return h | 16'h8000;
    end
  endfunction

endpackage

// File: rtl/half_gt.sv
// Purpose: strict greater-than for two half-precision values (NaN lowest, -0 == +0).
// Latency: combinational.
// Backpressure: n/a.
// Ports: a, b - operands; gt - 1 when a > b under the ordering above.
module half_gt
  import half_pkg::*;
(
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        gt
);

  // A NaN never beats anything; any non-NaN beats a NaN.
  assign gt = !half_is_nan(a) &&
              (half_is_nan(b) || (half_order_key(a) > half_order_key(b)));

endmodule

// File: rtl/half_predict_driver.sv
// Purpose: drives one start/done inference run per request and reports the argmax class.
// Latency: result strobe N+1 cycles after the done edge, or TIMEOUT_CYCLES cycles after entering WAIT.
// Backpressure: req_ready is high only in IDLE; results are a strobe with no downstream stall.
// Ports: clk/rst (sync active-high); req_valid/req_ready/req_label request handshake;
//        cnt_clear clears counters; pred_start/pred_done/pred_y core interface;
//        res_valid/res_class/res_max/res_correct/res_timeout result; total_count/correct_count.
module half_predict_driver
  import half_pkg::*;
#(
  parameter int OUTPUT_NODES   = 10,
  parameter int IDX_W          = $clog2(OUTPUT_NODES),
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [IDX_W-1:0]           req_label,
  input  logic                       cnt_clear,
  output logic                       pred_start,
  input  logic                       pred_done,
  input  logic [16*OUTPUT_NODES-1:0] pred_y,
  output logic                       res_valid,
  output logic [IDX_W-1:0]           res_class,
  output logic [15:0]                res_max,
  output logic                       res_correct,
  output logic                       res_timeout,
  output logic [31:0]                total_count,
  output logic [31:0]                correct_count
);

  localparam int                 TMR_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [TMR_W-1:0]   TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'(OUTPUT_NODES - 1);
  localparam logic [31:0]        CNT_MAX  = 32'hFFFF_FFFF;

  drv_state_t        state, state_nxt;
  logic              done_d;
  logic              done_edge;
  logic [IDX_W-1:0]  label_q;
  logic [TMR_W-1:0]  timer;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  best_idx;
  half_t             best_val;
  half_t             snap [OUTPUT_NODES];
  half_t             cur_val;
  logic              cur_gt;
  logic              take_cur;
  logic [IDX_W-1:0]  fin_idx;
  half_t             fin_val;

  assign done_edge = pred_done & ~done_d;

  // Scan datapath: element 0 always seeds the running best, later ones must
  // be strictly greater so ties stay on the lowest index.
  assign cur_val  = snap[idx];
  assign take_cur = (idx == '0) || cur_gt;
  assign fin_idx  = take_cur ? idx : best_idx;
  assign fin_val  = take_cur ? cur_val : best_val;

  half_gt u_gt (
    .a  (cur_val),
    .b  (best_val),
    .gt (cur_gt)
  );

  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    pred_start = 1'b0;
    res_valid  = 1'b0;
    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = ST_START;
      end
      ST_START: begin
        pred_start = 1'b1;
        state_nxt  = ST_WAIT;
      end
      ST_WAIT: begin
        // The done edge is checked first so it wins over a same-cycle timeout.
        if (done_edge)              state_nxt = ST_SCAN;
        else if (timer == TMR_LAST) state_nxt = ST_REPORT;
      end
      ST_SCAN: begin
        if (idx == IDX_LAST) state_nxt = ST_REPORT;
      end
      ST_REPORT: begin
        res_valid = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      done_d      <= 1'b0;
      label_q     <= '0;
      timer       <= '0;
      idx         <= '0;
      best_idx    <= '0;
      best_val    <= '0;
      res_class   <= '0;
      res_max     <= '0;
      res_correct <= 1'b0;
      res_timeout <= 1'b0;
      for (int i = 0; i < OUTPUT_NODES; i++) snap[i] <= '0;
    end else begin
      state  <= state_nxt;
      done_d <= pred_done;
      case (state)
        ST_IDLE: begin
          if (req_valid) label_q <= req_label;
        end
        ST_START: begin
          timer <= '0;
        end
        ST_WAIT: begin
          if (done_edge) begin
            for (int i = 0; i < OUTPUT_NODES; i++) snap[i] <= pred_y[16*i +: 16];
            idx <= '0;
          end else begin
            timer <= timer + 1'b1;
            if (timer == TMR_LAST) begin
              res_class   <= '0;
              res_max     <= '0;
              res_correct <= 1'b0;
              res_timeout <= 1'b1;
            end
          end
        end
        ST_SCAN: begin
          idx <= idx + 1'b1;
          if (take_cur) begin
            best_idx <= idx;
            best_val <= cur_val;
          end
          // Result registers load on the last element so they are valid
          // throughout the REPORT cycle.
          if (idx == IDX_LAST) begin
            res_class   <= fin_idx;
            res_max     <= fin_val;
            res_correct <= (fin_idx == label_q);
            res_timeout <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Counters saturate; a clear in the same cycle as a report drops that report.
  always_ff @(posedge clk) begin
    if (rst || cnt_clear) begin
      total_count   <= '0;
      correct_count <= '0;
    end else if (state == ST_REPORT) begin
      if (total_count != CNT_MAX) total_count <= total_count + 32'd1;
      if (res_correct && (correct_count != CNT_MAX)) correct_count <= correct_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_half_predict_driver.sv
// Purpose: directed self-checking bench for half_predict_driver (N=10, timeout 8).
// Latency: n/a.
// Backpressure: n/a.
module tb_half_predict_driver;

  localparam int N  = 10;
  localparam int IW = 4;
  localparam int TO = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic [IW-1:0]     req_label;
  logic              cnt_clear;
  logic              pred_start;
  logic              pred_done;
  logic [16*N-1:0]   pred_y;
  logic              res_valid;
  logic [IW-1:0]     res_class;
  logic [15:0]       res_max;
  logic              res_correct;
  logic              res_timeout;
  logic [31:0]       total_count;
  logic [31:0]       correct_count;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  half_predict_driver #(
    .OUTPUT_NODES   (N),
    .IDX_W          (IW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_label     (req_label),
    .cnt_clear     (cnt_clear),
    .pred_start    (pred_start),
    .pred_done     (pred_done),
    .pred_y        (pred_y),
    .res_valid     (res_valid),
    .res_class     (res_class),
    .res_max       (res_max),
    .res_correct   (res_correct),
    .res_timeout   (res_timeout),
    .total_count   (total_count),
    .correct_count (correct_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [16*N-1:0] fill(input logic [15:0] v);
    logic [16*N-1:0] r;
    for (int i = 0; i < N; i++) r[16*i +: 16] = v;
    return r;
  endfunction

  // Issue one request from a mid-cycle point in IDLE. dly>0: done edge that
  // many cycles after the START cycle; dly==0: pred_done is left as is.
  task automatic do_req(input string tag, input logic [IW-1:0] lbl,
                        input logic [16*N-1:0] y, input int dly, input int exp_lat,
                        input bit clr, input logic [IW-1:0] e_cls, input logic [15:0] e_max,
                        input logic e_cor, input logic e_to);
    int n;
    chk({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_label = lbl;
    @(negedge clk);
    req_valid = 1'b0;
    req_label = '0;
    chk({tag, "_start"}, {31'd0, pred_start}, 32'd1);
    n = 0;
    while (n < 60 && !res_valid) begin
      @(negedge clk);
      n++;
      if (n == 1) chk({tag, "_start_pulse"}, {31'd0, pred_start}, 32'd0);
      if (dly > 0 && n == dly) begin
        pred_done = 1'b1;
        pred_y    = y;
      end
      if (dly > 0 && n == dly + 1) begin
        pred_done = 1'b0;
        pred_y    = ~y;
      end
    end
    chk({tag, "_latency"}, n, exp_lat);
    chk({tag, "_class"},   {28'd0, res_class}, {28'd0, e_cls});
    chk({tag, "_max"},     {16'd0, res_max}, {16'd0, e_max});
    chk({tag, "_correct"}, {31'd0, res_correct}, {31'd0, e_cor});
    chk({tag, "_timeout"}, {31'd0, res_timeout}, {31'd0, e_to});
    if (clr) cnt_clear = 1'b1;
    @(negedge clk);
    cnt_clear = 1'b0;
    chk({tag, "_valid_drop"}, {31'd0, res_valid}, 32'd0);
    chk({tag, "_hold_class"}, {28'd0, res_class}, {28'd0, e_cls});
  endtask

  task automatic chk_cnt(input string tag, input logic [31:0] e_tot, input logic [31:0] e_cor);
    chk({tag, "_total"},   total_count, e_tot);
    chk({tag, "_correct_cnt"}, correct_count, e_cor);
  endtask

  initial begin
    logic [16*N-1:0] y;
    int seen;

    rst       = 1'b1;
    req_valid = 1'b0;
    req_label = '0;
    cnt_clear = 1'b0;
    pred_done = 1'b0;
    pred_y    = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready",   {31'd0, req_ready}, 32'd1);
    chk("rst_valid",   {31'd0, res_valid}, 32'd0);
    chk("rst_start",   {31'd0, pred_start}, 32'd0);
    chk("rst_class",   {28'd0, res_class}, 32'd0);
    chk("rst_max",     {16'd0, res_max}, 32'd0);
    chk_cnt("rst", 32'd0, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Basic argmax: D = S+5, report at D+11.
    y = fill(16'h3C00);
    y[16*3 +: 16] = 16'h4000;
    do_req("basic", 4'd3, y, 5, 16, 1'b0, 4'd3, 16'h4000, 1'b1, 1'b0);
    chk_cnt("basic", 32'd1, 32'd1);

    // Negative values with a tie: lowest index wins.
    y = fill(16'hBC00);
    y[16*2 +: 16] = 16'hB800;
    y[16*7 +: 16] = 16'hB800;
    do_req("tie_neg", 4'd2, y, 3, 14, 1'b0, 4'd2, 16'hB800, 1'b1, 1'b0);
    chk_cnt("tie_neg", 32'd2, 32'd2);

    // -0 then +0: equal, so index 0 stays.
    y = fill(16'hBC00);
    y[16*0 +: 16] = 16'h8000;
    y[16*1 +: 16] = 16'h0000;
    do_req("zeros", 4'd1, y, 2, 13, 1'b0, 4'd0, 16'h8000, 1'b0, 1'b0);
    chk_cnt("zeros", 32'd3, 32'd2);

    // NaN at 0 ranks lowest, +inf wins.
    y = fill(16'h3C00);
    y[16*0 +: 16] = 16'h7E00;
    y[16*4 +: 16] = 16'h7C00;
    do_req("nan_inf", 4'd4, y, 4, 15, 1'b0, 4'd4, 16'h7C00, 1'b1, 1'b0);
    chk_cnt("nan_inf", 32'd4, 32'd3);

    // All NaN: class 0 with its raw bits.
    do_req("all_nan", 4'd0, fill(16'h7E00), 5, 16, 1'b0, 4'd0, 16'h7E00, 1'b1, 1'b0);
    chk_cnt("all_nan", 32'd5, 32'd4);

    // Positive tie at 5 and 8, wrong label.
    y = fill(16'h3C00);
    y[16*5 +: 16] = 16'h4400;
    y[16*8 +: 16] = 16'h4400;
    do_req("tie_pos", 4'd9, y, 6, 17, 1'b0, 4'd5, 16'h4400, 1'b0, 1'b0);
    chk_cnt("tie_pos", 32'd6, 32'd4);

    // Done level held from before: no edge, timeout 8 cycles after WAIT entry.
    pred_done = 1'b1;
    @(negedge clk);
    do_req("timeout", 4'd0, fill(16'h3C00), 0, 9, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b1);
    chk_cnt("timeout", 32'd7, 32'd4);
    pred_done = 1'b0;
    @(negedge clk);

    // Clear coincident with the report wins.
    y = fill(16'h3C00);
    y[16*3 +: 16] = 16'h4000;
    do_req("clear", 4'd3, y, 5, 16, 1'b1, 4'd3, 16'h4000, 1'b1, 1'b0);
    chk_cnt("clear", 32'd0, 32'd0);

    // Saturation of the total counter.
    force dut.total_count = 32'hFFFF_FFFF;
    #1;
    release dut.total_count;
    do_req("sat", 4'd3, y, 5, 16, 1'b0, 4'd3, 16'h4000, 1'b1, 1'b0);
    chk_cnt("sat", 32'hFFFF_FFFF, 32'd1);

    // Reset in the middle of SCAN (D+4).
    req_valid = 1'b1;
    req_label = 4'd3;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (5) @(negedge clk);
    pred_done = 1'b1;
    pred_y    = y;
    @(negedge clk);
    pred_done = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_ready", {31'd0, req_ready}, 32'd1);
    chk("mid_rst_valid", {31'd0, res_valid}, 32'd0);
    chk_cnt("mid_rst", 32'd0, 32'd0);
    rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (res_valid || pred_start) seen++;
    end
    chk("mid_rst_no_late", seen, 32'd0);
    do_req("after_rst", 4'd3, y, 5, 16, 1'b0, 4'd3, 16'h4000, 1'b1, 1'b0);
    chk_cnt("after_rst", 32'd1, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
